// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: state, exception cause and PC source codes.
// Pure declarations; no timing or flow-control behaviour of its own.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_EXCP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_NONE   = 2'b00,
    C_EXCP   = 2'b01,
    C_IRQ    = 2'b10,
    C_RWCONF = 2'b11
  } cause_t;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_VEC  = 2'b01;

endpackage

// File: rtl/mc_ctrl_if.sv
// Sequencer bundle: memory handshake, EX-stage status, latch/write strobes and debug state.
// Memory side holds off with mem_ack low; the sequencer keeps mem_req asserted until acked.
interface mc_ctrl_if;
  logic        mem_ack;
  logic        ex_read;
  logic        ex_write;
  logic        ex_excp;
  logic [4:0]  regaddr;
  logic        irq;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic        ir_we;
  logic        ab_we;
  logic        c_we;
  logic        mdr_we;
  logic        reg_we;
  logic        reg_src_mem;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        epc_we;
  logic [1:0]  cause;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    input  mem_ack, ex_read, ex_write, ex_excp, regaddr, irq,
    output mem_req, mem_we, mem_is_fetch, ir_we, ab_we, c_we, mdr_we,
           reg_we, reg_src_mem, pc_we, pc_src, epc_we, cause, state, instret
  );

  modport slave (
    output mem_ack, ex_read, ex_write, ex_excp, regaddr, irq,
    input  mem_req, mem_we, mem_is_fetch, ir_we, ab_we, c_we, mdr_we,
           reg_we, reg_src_mem, pc_we, pc_src, epc_we, cause, state, instret
  );
endinterface

// File: rtl/mc_ctrl_retire_cnt.sv
// Retired-instruction counter, wraps modulo 2^32; updates on the edge where en is high.
// No backpressure: counts whenever enabled, async clear.
module retire_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 32'd0;
    else if (en)
      cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer; 4 cycles ALU/exception, 5 load/store, +1 interrupt.
// Stalls in FETCH or MEM while mem_ack is low, holding mem_req, address select and mem_we steady.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  state_t      state_q, state_nx;
  logic        is_ld, is_st;
  cause_t      cause_q, cause_nx;
  logic        cause_ld;
  logic        retire;
  logic [31:0] instret_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      is_ld   <= 1'b0;
      is_st   <= 1'b0;
      cause_q <= C_NONE;
    end else begin
      state_q <= state_nx;
      if (state_q == S_EXEC) begin
        is_ld <= bus.ex_read;
        is_st <= bus.ex_write;
      end
      if (cause_ld)
        cause_q <= cause_nx;
    end
  end

  always_comb begin
    state_nx         = state_q;
    cause_nx         = cause_q;
    cause_ld         = 1'b0;
    retire           = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_is_fetch = 1'b0;
    bus.ir_we        = 1'b0;
    bus.ab_we        = 1'b0;
    bus.c_we         = 1'b0;
    bus.mdr_we       = 1'b0;
    bus.reg_we       = 1'b0;
    bus.reg_src_mem  = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = PC_NEXT;
    bus.epc_we       = 1'b0;

    unique case (state_q)
      S_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        bus.mem_req      = 1'b1;
        bus.mem_is_fetch = 1'b1;
        bus.ir_we        = bus.mem_ack;
        if (bus.mem_ack)
          state_nx = S_DECODE;
      end

      S_DECODE: begin
        bus.ab_we = 1'b1;
        state_nx  = S_EXEC;
      end

      S_EXEC: begin
        bus.c_we = 1'b1;
        if (bus.ex_excp) begin
          state_nx = S_EXCP;
          cause_nx = C_EXCP;
          cause_ld = 1'b1;
        end else if (bus.ex_read && bus.ex_write) begin
          state_nx = S_EXCP;
          cause_nx = C_RWCONF;
          cause_ld = 1'b1;
        end else if (bus.ex_read || bus.ex_write) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end

      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = is_st;
        bus.mdr_we  = bus.mem_ack & is_ld;
        if (bus.mem_ack)
          state_nx = S_WB;
      end

      S_WB: begin
        bus.reg_we      = (bus.regaddr != 5'd0) & ~is_st;
        bus.reg_src_mem = is_ld;
        bus.pc_we       = 1'b1;
        retire          = 1'b1;
        // irq is only looked at here, so an excepting instruction can never report it
        if (bus.irq) begin
          state_nx = S_EXCP;
          cause_nx = C_IRQ;
          cause_ld = 1'b1;
        end else begin
          state_nx = S_FETCH;
        end
      end

      S_EXCP: begin
        bus.epc_we = 1'b1;
        bus.pc_we  = 1'b1;
        bus.pc_src = PC_VEC;
        state_nx   = S_FETCH;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  retire_cnt u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .en  (retire),
    .cnt (instret_cnt)
  );

  assign bus.instret = instret_cnt;
  assign bus.cause   = cause_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks ALU, load, store, exception, interrupt and reset-mid-request cases.
// Inputs driven 2ns after the rising edge, outputs checked 1ns later.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // strobe word: req we fetch ir ab c mdr reg_we src_mem pc_we pc_src[1:0] epc_we
  localparam logic [12:0] W_IDLE   = 13'b0000000000000;
  localparam logic [12:0] W_F_ACK  = 13'b1011000000000;
  localparam logic [12:0] W_F_WAIT = 13'b1010000000000;
  localparam logic [12:0] W_DEC    = 13'b0000100000000;
  localparam logic [12:0] W_EXE    = 13'b0000010000000;
  localparam logic [12:0] W_M_RD   = 13'b1000000000000;
  localparam logic [12:0] W_M_LDAK = 13'b1000001000000;
  localparam logic [12:0] W_M_ST   = 13'b1100000000000;
  localparam logic [12:0] W_WB_ALU = 13'b0000000101000;
  localparam logic [12:0] W_WB_LD  = 13'b0000000111000;
  localparam logic [12:0] W_WB_ST  = 13'b0000000001000;
  localparam logic [12:0] W_EXCP   = 13'b0000000001011;

  function automatic logic [12:0] strobes();
    return {bus.mem_req, bus.mem_we, bus.mem_is_fetch, bus.ir_we, bus.ab_we, bus.c_we,
            bus.mdr_we, bus.reg_we, bus.reg_src_mem, bus.pc_we, bus.pc_src, bus.epc_we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic ack, input logic rd, input logic wr, input logic ex,
                     input logic [4:0] ra, input logic irq);
    bus.mem_ack  = ack;
    bus.ex_read  = rd;
    bus.ex_write = wr;
    bus.ex_excp  = ex;
    bus.regaddr  = ra;
    bus.irq      = irq;
  endtask

  task automatic ck(input string tag, input logic [2:0] st, input logic [12:0] w);
    #1;
    chk({tag, ".state"}, {29'd0, bus.state}, {29'd0, st});
    chk({tag, ".strb"}, {19'd0, strobes()}, {19'd0, w});
  endtask

  initial begin
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (2) nxt();
    ck("rst", 3'd0, W_IDLE);
    chk("rst.cause", {30'd0, bus.cause}, 32'd0);
    chk("rst.instret", bus.instret, 32'd0);
    rst = 1'b0;

    // ALU op, zero-wait
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("alu.f", 3'd1, W_F_ACK);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("alu.d", 3'd2, W_DEC);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0); ck("alu.e", 3'd3, W_EXE);
    nxt(); ck("alu.w", 3'd5, W_WB_ALU);
    chk("alu.w.instret", bus.instret, 32'd0);

    // load with two MEM wait states
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("ld.f", 3'd1, W_F_ACK);
    chk("alu.instret", bus.instret, 32'd1);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("ld.d", 3'd2, W_DEC);
    nxt(); drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0); ck("ld.e", 3'd3, W_EXE);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0); ck("ld.m0", 3'd4, W_M_RD);
    nxt(); ck("ld.m1", 3'd4, W_M_RD);
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0); ck("ld.m2", 3'd4, W_M_LDAK);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0); ck("ld.w", 3'd5, W_WB_LD);

    // store to regaddr 3 with one wait state
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("st.f", 3'd1, W_F_ACK);
    chk("ld.instret", bus.instret, 32'd2);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("st.d", 3'd2, W_DEC);
    nxt(); drv(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0); ck("st.e", 3'd3, W_EXE);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0); ck("st.m0", 3'd4, W_M_ST);
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0); ck("st.m1", 3'd4, W_M_ST);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0); ck("st.w", 3'd5, W_WB_ST);

    // EX exception with irq raised at the same time
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("ex.f", 3'd1, W_F_ACK);
    chk("st.instret", bus.instret, 32'd3);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("ex.d", 3'd2, W_DEC);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1); ck("ex.e", 3'd3, W_EXE);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); ck("ex.x", 3'd6, W_EXCP);
    chk("ex.cause", {30'd0, bus.cause}, 32'd1);
    chk("ex.instret", bus.instret, 32'd3);

    // pending irq is taken after the next retired instruction
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); ck("irq.f", 3'd1, W_F_ACK);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); ck("irq.d", 3'd2, W_DEC);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1); ck("irq.e", 3'd3, W_EXE);
    nxt(); ck("irq.w", 3'd5, W_WB_ALU);
    chk("irq.w.cause", {30'd0, bus.cause}, 32'd1);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("irq.x", 3'd6, W_EXCP);
    chk("irq.cause", {30'd0, bus.cause}, 32'd2);
    chk("irq.instret", bus.instret, 32'd4);

    // read/write conflict
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rw.f", 3'd1, W_F_ACK);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rw.d", 3'd2, W_DEC);
    nxt(); drv(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0); ck("rw.e", 3'd3, W_EXE);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rw.x", 3'd6, W_EXCP);
    chk("rw.cause", {30'd0, bus.cause}, 32'd3);
    chk("rw.instret", bus.instret, 32'd4);

    // stray acks in DECODE/EXEC, then reset while MEM request is outstanding
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rr.f", 3'd1, W_F_ACK);
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rr.d", 3'd2, W_DEC);
    nxt(); drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0); ck("rr.e", 3'd3, W_EXE);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0); ck("rr.m", 3'd4, W_M_RD);
    rst = 1'b1;
    ck("rr.rst", 3'd0, W_IDLE);
    chk("rr.rst.instret", bus.instret, 32'd0);
    chk("rr.rst.cause", {30'd0, bus.cause}, 32'd0);
    nxt(); rst = 1'b0; ck("rr.idle", 3'd0, W_IDLE);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rr.fw0", 3'd1, W_F_WAIT);
    nxt(); ck("rr.fw1", 3'd1, W_F_WAIT);
    nxt(); drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rr.fa", 3'd1, W_F_ACK);
    nxt(); drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); ck("rr.d2", 3'd2, W_DEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle sequencer for the MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the latch strobes around the EX stage (IR, operand A/B, result C, MDR) and the register-file and PC write enables. It owns the memory request/acknowledge handshake and redirects control flow on EX-stage exceptions and external interrupts.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_ack` in 1: memory completes the current request this cycle.
- `ex_read` in 1: EX reports a load; valid in EXEC.
- `ex_write` in 1: EX reports a store; valid in EXEC.
- `ex_excp` in 1: EX reports an exception; valid in EXEC.
- `regaddr` in 5: EX destination register; 0 means no writeback; valid EXEC through WB.
- `irq` in 1: level interrupt request.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: request is a store.
- `mem_is_fetch` out 1: address mux select, 1 = PC, 0 = result C.
- `ir_we`, `ab_we`, `c_we`, `mdr_we` out 1 each: latch strobes.
- `reg_we` out 1: register-file write enable.
- `reg_src_mem` out 1: writeback data select, 1 = MDR, 0 = C.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: PC source select, 00 = EX next-PC, 01 = exception vector.
- `epc_we` out 1: EPC write enable.
- `cause` out 2: registered exception cause.
- `state` out 3: current state, for debug.
- `instret` out 32: retired-instruction count.

## Operation
States:
- IDLE, FETCH, DECODE, EXEC, MEM, WB, EXCP.
- Outputs are decoded from state; some strobes are also qualified by inputs, as listed per state.

IDLE:
- All strobes are 0.
- Next state is FETCH on the following cycle.

FETCH:
- `mem_req`=1, `mem_is_fetch`=1, `mem_we`=0.
- `ir_we` = `mem_ack`.
- Goes to DECODE on `mem_ack`; otherwise stays in FETCH.

DECODE:
- `ab_we`=1.
- Goes to EXEC.

EXEC:
- `c_we`=1.
- Captures `ex_read` and `ex_write` into internal flags `is_ld` and `is_st`.
- Next state, in priority order:
  - EXCP, with cause 01, if `ex_excp`.
  - EXCP, with cause 11, if both `ex_read` and `ex_write` are set.
  - MEM if either `ex_read` or `ex_write` is set.
  - WB otherwise.

MEM:
- `mem_req`=1, `mem_is_fetch`=0, `mem_we` = `is_st`.
- `mdr_we` = `mem_ack` & `is_ld`.
- Goes to WB on `mem_ack`.

WB:
- `reg_we` = (`regaddr` != 0) & !`is_st`.
- `reg_src_mem` = `is_ld`.
- `pc_we`=1, `pc_src`=00.
- `instret` increments by 1, wrapping modulo 2^32.
- Next state is EXCP with cause 10 if `irq`; otherwise FETCH.

EXCP:
- `epc_we`=1, `pc_we`=1, `pc_src`=01.
- `cause` takes the pending code.
- Goes to FETCH.

EPC contents:
- On an EX exception the PC has not yet been updated, so EPC receives the faulting PC.
- On an interrupt, EPC receives the next-instruction PC, because WB has already committed.

Handshake rules:
- `mem_ack` is ignored outside FETCH and MEM.
- `mem_req` never drops before the acknowledging cycle.
- The address select and `mem_we` are stable for the whole request.

Simultaneous events:
- `ex_excp` together with `irq`: the exception is taken and the interrupt stays pending.
  - `irq` is sampled only in WB.
  - It is therefore taken after the next retired instruction.
- `irq` during an excepting instruction never sets cause 10 for that instruction.

Reset:
- Asynchronous reset forces state IDLE.
- Clears `is_ld`, `is_st`, `cause` (to 00) and `instret` (to 0).
- All strobes drop to 0 in the same cycle, including `mem_req` mid-request; memory must abandon an outstanding access.

## Timing
- Reset values: every 1-bit output 0, `pc_src`=00, `cause`=00, `state`=IDLE, `instret`=0.
- FETCH is entered on the first rising edge after `rst` deasserts.

Latency with zero-wait memory (`mem_ack` high in the request cycle):
- ALU or branch instruction: 4 cycles (F, D, E, W).
- Load or store: 5 cycles.
- EX exception: 4 cycles (F, D, E, X).
- Interrupt: adds 1 cycle after WB.

Wait states:
- Each cycle that `mem_ack` stays low adds one cycle in FETCH or MEM.

Strobe timing:
- `ir_we` and `mdr_we` are asserted in the same cycle as `mem_ack`, so data is captured on that edge.
- `instret` is updated on the edge that leaves WB.

## Structure
- Package `mc_pkg` holds:
  - the state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, EXCP=6;
  - the cause codes: NONE=00, EXCP=01, IRQ=10, RWCONF=11;
  - the `pc_src` codes.
- One sub-module, `retire_cnt`: 32-bit counter with async clear and increment enable, instantiated for `instret`.
- All other logic is a single FSM with a registered state and combinational output decode.

## Test plan
- **Reset then ALU op:** zero-wait ack, `regaddr`=5 -> `ir_we` cycle 1, `ab_we` cycle 2, `c_we` cycle 3, `reg_we`/`pc_we` cycle 4, `instret`=1.
- **Load with 2 wait states in MEM:** `ex_read`=1, `regaddr`=8 -> `mem_req` held 3 cycles with `mem_is_fetch`=0 and `mem_we`=0; `mdr_we` only in the ack cycle; WB has `reg_src_mem`=1 and `reg_we`=1.
- **Store with `regaddr`=3:** `ex_write`=1 -> `mem_we`=1 throughout MEM; WB has `reg_we`=0 and `pc_we`=1.
- **Exception and conflict:**
  - `ex_excp`=1 in EXEC -> EXCP with `epc_we`=1, `pc_src`=01, `cause`=01, `instret` unchanged.
  - `ex_read`=`ex_write`=1 -> `cause`=11.
- **Interrupt priority:**
  - `irq` held high across an ALU op -> WB retires (`instret` +1), then EXCP with `cause`=10.
  - `irq` together with `ex_excp` -> `cause`=01 first; the interrupt is taken after the next instruction.
- **Reset mid-request:** assert `rst` while in MEM with `mem_req`=1 -> `mem_req`=0 in the same cycle, `state`=IDLE, `instret`=0; after release, FETCH follows one cycle later. Stray `mem_ack` pulses in DECODE or EXEC have no effect.
